// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; bytes are framed LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W        = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [OCC_W-1:0]    r_occ;
    logic [OCC_W-1:0]    w_occ_next;

    logic                r_ready;
    logic                r_tx;
    logic                r_busy;
    logic                r_stop_end;
    logic                r_done;
    logic                r_overflow;

    logic                w_bit_end;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_tx;
    logic                w_stop_end;

`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_empty   = (r_occ == '0);
    assign w_push    = data_valid && r_ready;

    // Frame sequencing; outputs are registered one cycle behind the state
    always_comb begin
        w_next_state   = r_state;
        w_baud_next    = w_bit_end ? '0 : r_baud + BAUD_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_tx           = 1'b1;
        w_stop_end     = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_next_state = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_next_state   = DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_next_state = PARITY;
`else
                        w_next_state = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx = r_parity;
                if (w_bit_end) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    w_stop_end = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being popped, held for the whole frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^r_mem[r_rd_ptr];
        end
    end
`endif

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + OCC_W'(1);
            2'b01:   w_occ_next = r_occ - OCC_W'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    // Storage array carries no reset; occupancy alone defines validity
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ   <= w_occ_next;
            r_ready <= (w_occ_next != OCC_FULL);
        end
    end

    // tx_done trails the last stop cycle by one so it lines up with the registered tx
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_stop_end <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tx       <= w_tx;
            r_busy     <= (r_state != IDLE);
            r_stop_end <= w_stop_end;
            r_done     <= r_stop_end;
            if (data_valid && !r_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ready    = r_ready;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign overflow = r_overflow;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that serialises result bytes back to the host over the same 8N1 serial link that UART_RX receives on.
- A small FIFO decouples byte producers (ALU result path, status reporting) from the bit-rate serialiser, so short bursts are accepted at clock rate.
- Sits beside UART_RX in the ALU top level; its tx output drives the board's serial TX pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- FIFO_DEPTH, 4, bytes of buffering; power of two, minimum 2.
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; must be at least 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  8  byte to transmit.
- data_valid  input  1  write strobe; value is captured on a clock edge where data_valid=1 and ready=1.
- ready  output  1  1 when the FIFO is not full.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  1 while a frame is on the line (START through STOP).
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- overflow  output  1  sticky flag; set when data_valid=1 while ready=0.

Behaviour:
- Reset, asynchronous and immediate:
  - tx=1, ready=1, tx_busy=0, tx_done=0, overflow=0.
  - FIFO emptied, state=IDLE, all counters cleared.
  - Reset mid-frame aborts the frame: tx goes high at once and no tx_done is issued.
- All outputs are registered.
- FIFO:
  - Write when data_valid && !full.
  - ready = !full, based on occupancy before the edge. A write while full is rejected even if a pop happens in the same cycle.
  - A simultaneous write and pop while not full is legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A rejected write sets overflow. overflow is cleared only by reset.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, go to START, assert tx_busy.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, pulse tx_done.
    - FIFO non-empty: pop and go directly to START. There are no idle bit-times between frames.
    - FIFO empty: go to IDLE and deassert tx_busy.
- Latency: data_valid sampled at edge N with the FIFO empty and state IDLE → byte written at edge N, popped at edge N+1, tx low from edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- The baud counter runs from 0 to CLKS_PER_BIT-1 and reloads on every bit boundary. There is no fractional-baud correction.
- value is sampled only on an accepted write. Changing value afterwards has no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 8E1, 11 bits.
- Undefined: no PARITY state, no parity logic, 8N1 frame.

Test Plan:
- Reset check: assert reset mid-run → tx=1, ready=1, tx_busy=0, tx_done=0, overflow=0 without waiting for a clock edge.
- Single byte, CLK_FREQ=40, BAUD=10 (CLKS_PER_BIT=4): write 0x35 → tx falls 2 cycles after the strobe. Mid-bit samples are 0,1,0,1,0,1,1,0,0,1. tx_done pulses once, 40 cycles after tx falls. tx_busy is low the next cycle.
- Burst with FIFO_DEPTH=4: 6 consecutive strobes of 0x01..0x06 → 0x01..0x05 are transmitted in order, back-to-back with no idle gap. 0x06 is dropped, overflow=1, ready=0 during the 6th strobe.
- Back-to-back: write 0xA5, then write 0x3C during the first frame → the stop bit of 0xA5 is followed immediately by the start bit of 0x3C. Exactly 2 tx_done pulses, 40 cycles apart.
- Reset mid-frame: reset during data bit 3 of 0xFF → tx=1 at once, no tx_done, FIFO empty. A new write of 0x55 after reset transmits correctly.
- UART_TX_PARITY_EN defined: 0x07 → parity bit 1; 0x03 → parity bit 0. Frame length 44 cycles at CLKS_PER_BIT=4.
